// File: rtl/mux_pkg.sv
// Shared constants for the stream multiplexer family.
// DEF_N : default number of input channels
// DEF_W : default data width per channel
package mux_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

endpackage : mux_pkg

// File: rtl/rr_arbiter.sv
// Round-robin / forced-select arbiter for rr_stream_mux.
// Ports:
//   req       - per-channel request (the input valids)
//   ptr       - index of the last granted channel; ptr+1 has top priority
//   force_en  - 1 = grant only force_sel, 0 = round-robin
//   force_sel - channel index used when force_en=1 (values >= N grant nothing)
//   grant     - one-hot or all-zero grant
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 force_en,
  input  logic [$clog2(N)-1:0] force_sel,
  output logic [N-1:0]         grant
);

  localparam int SEL_W = $clog2(N);

  logic [SEL_W:0]   shamt;
  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     rot;
  logic [N-1:0]     rot_first;
  logic [2*N-1:0]   first_dbl;
  logic [N-1:0]     grant_rr;
  logic [N-1:0]     grant_force;

  // Rotate so that channel ptr+1 sits at bit 0. ptr+1 can equal N, which
  // the doubled vector still covers (ptr itself lands at bit N-1).
  assign shamt   = {1'b0, ptr} + (SEL_W+1)'(1);
  assign req_dbl = {req, req};
  assign rot     = N'(req_dbl >> shamt);

  // Lowest set bit of the rotated request is the winner.
  assign rot_first = rot & (~rot + N'(1));

  // Rotate the winner back; the upper half of the doubled vector holds the
  // result in channel order regardless of whether the rotation wrapped.
  assign first_dbl = {rot_first, rot_first} << shamt;
  assign grant_rr  = first_dbl[2*N-1:N];

  always_comb begin
    grant_force = '0;
    for (int i = 0; i < N; i++) begin
      grant_force[i] = req[i] && (force_sel == SEL_W'(i));
    end
  end

  assign grant = force_en ? grant_force : grant_rr;

endmodule : rr_arbiter

// File: rtl/rr_stream_mux.sv
// N-channel registered stream multiplexer with valid/ready handshakes and
// round-robin (or forced) channel selection.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   in_data  [N*W]        - channel i at bits [i*W +: W]
//   in_valid [N]          - per-channel valid
//   in_ready [N]          - per-channel ready (combinational, at most one high)
//   force_en, force_sel   - fixed-select mode and its channel index
//   out_data, out_valid   - registered output beat
//   out_sel               - registered index of the channel behind out_data
//   out_ready             - consumer ready
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*W-1:0]       in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 force_en,
  input  logic [$clog2(N)-1:0] force_sel,
  output logic [W-1:0]         out_data,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_sel,
  input  logic                 out_ready
);

  localparam int SEL_W = $clog2(N);

  logic [SEL_W-1:0] ptr;
  logic [N-1:0]     grant;
  logic             load_en;
  logic             any_grant;
  logic [SEL_W-1:0] gnt_idx;
  logic [W-1:0]     gnt_data;

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .force_en  (force_en),
    .force_sel (force_sel),
    .grant     (grant)
  );

  // The register accepts a beat when empty or when being drained this cycle.
  assign load_en   = !out_valid || out_ready;
  assign in_ready  = grant & {N{load_en}};
  assign any_grant = |grant;

  // Grant is one-hot, so an AND-OR select is enough.
  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        gnt_idx = SEL_W'(i);
      end
      gnt_data = gnt_data | (in_data[i*W +: W] & {W{grant[i]}});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SEL_W'(N-1);
    end else if (load_en) begin
      if (any_grant) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_sel   <= gnt_idx;
        ptr       <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule : rr_stream_mux

// File: doc/rr_stream_mux.md
# rr_stream_mux

Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshakes and round-robin arbitration. It generalises the gate-level 2:1 mux from a single select bit to N streaming sources with fair arbitration and an optional forced-select mode. It sits between several producer streams and one consumer; the output is registered, so each accepted beat appears one cycle later. It is the first block in this family with clocked state.

## Interface
- N, default 4: number of input channels, N >= 2.
- W, default 8: data width per channel, W >= 1.
- SEL_W, derived as $clog2(N), not overridable: width of channel index.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- force_en  input  1  1 = fixed-select mode, 0 = round-robin.
- force_sel  input  SEL_W  channel index used when force_en=1.
- out_data  output  W  registered data.
- out_valid  output  1  registered valid.
- out_sel  output  SEL_W  registered index of the channel that supplied out_data.
- out_ready  input  1  consumer ready.

## Operation
- State: output register (out_data, out_valid, out_sel) and round-robin pointer ptr (SEL_W bits, index of the last granted channel).
- load_en = !out_valid || out_ready. The register can take a new beat when it is empty or is being drained this cycle.
- Round-robin grant (force_en=0): the first i with in_valid[i]=1, searching ptr+1, ptr+2, … modulo N and wrapping past N-1 to 0. ptr itself is checked last. The grant is one-hot or zero.
- Forced grant (force_en=1): grant[force_sel]=in_valid[force_sel]; all other channels get no grant.
- A force_sel value >= N (possible only when N is not a power of 2) grants nothing.
- in_ready[i] = load_en && grant[i]. At most one in_ready bit is high; in_ready never depends on in_valid of another channel except through the grant.
- Transfer on channel g when in_valid[g] && in_ready[g]. At the next edge:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - ptr <= g, in both modes.
- When load_en=1 and there is no grant: out_valid <= 0; out_data and out_sel hold their values.
- When load_en=0: the register and ptr hold, and all in_ready are 0.
- out_data and out_sel are stable while out_valid=1 and out_ready=0.
- force_en may change on any cycle and takes effect on the same cycle's grant.

## Timing
- Reset values (asynchronous, applied immediately): out_valid=0, out_data=0, out_sel=0, ptr=N-1. After reset, channel 0 has first priority.
- Latency: one cycle from input handshake to out_valid.
- Throughput: one beat per cycle while out_ready=1 and any channel is valid.
- Fairness: with all N channels continuously valid and out_ready=1, grants rotate 0,1,…,N-1,0 with no channel skipped.
- Simultaneous drain and load: a beat consumed and a new beat loaded in the same cycle gives out_valid staying 1 with no bubble.
- Reset mid-operation: any held beat is discarded without being presented, and ptr returns to N-1.
- The in_ready path is combinational from in_valid, force_en, force_sel, out_valid and out_ready. There are no combinational paths from in_data to any output.

## Structure
- Shared package mux_pkg: no typedefs are required. It holds the default constants DEF_N=4 and DEF_W=8 for reuse by later mux variants.
- One natural sub-module: rr_arbiter.
  - Parameter: N.
  - Inputs: req[N], ptr, force_en, force_sel.
  - Output: one-hot grant[N].
  - Implemented as a double-width rotate-and-priority-encode.
- rr_stream_mux contains the output register, ptr, load_en logic and the data select. It stays independent of any gate-level primitives.

## Test plan
- Reset, then all channels idle: out_valid=0, out_sel=0, and in_ready=0 on every channel.
- N=4, W=8, in_data={8'h44,8'h33,8'h22,8'h11}, all valid, out_ready=1: out_sel sequence 0,1,2,3,0 and out_data 11,22,33,44,11, starting 1 cycle after the first handshake.
- Backpressure with the same stimulus and out_ready=0 for 3 cycles after the first beat: out_data=8'h11 is held, in_ready=0. When out_ready returns, the next beat is 8'h22 with no bubble.
- Sparse requests, only channels 1 and 3 valid with ptr=1: grant 3, then 1, then 3; channels 0 and 2 are never granted.
- force_en=1, force_sel=2, all valid: every beat is 8'h33 with out_sel=2. When force_en drops, round-robin resumes at channel 3.
- Assert rst while out_valid=1 and out_ready=0: out_valid=0 immediately. After release with all channels valid, the first beat is channel 0.
